// File: rtl/exu_resolve_if.sv
// exu_resolve_if
//   Bundles the EX-stage resolver's upstream handshake and operands, the
//   fetch redirect, and the downstream write-back handshake.
//   Ports (all interface signals, direction seen from the resolver):
//     upstream   : i_valid, o_ready, i_kind, i_brop, i_setlt, i_pc, i_imm,
//                  i_src1, i_src2, i_alu_res, i_sububit, i_rd, i_rd_wen
//     fetch      : o_redirect, o_redirect_pc
//     downstream : o_valid, i_ready, o_rd_data, o_rd, o_rd_wen
//   Modports: master = the environment around the resolver,
//             slave  = the resolver itself.
interface exu_resolve_if #(
  parameter int CPU_WIDTH = 32
);
  logic                 i_valid;
  logic                 o_ready;
  logic [1:0]           i_kind;
  logic [2:0]           i_brop;
  logic [1:0]           i_setlt;
  logic [CPU_WIDTH-1:0] i_pc;
  logic [CPU_WIDTH-1:0] i_imm;
  logic [CPU_WIDTH-1:0] i_src1;
  logic [CPU_WIDTH-1:0] i_src2;
  logic [CPU_WIDTH-1:0] i_alu_res;
  logic                 i_sububit;
  logic [4:0]           i_rd;
  logic                 i_rd_wen;
  logic                 o_redirect;
  logic [CPU_WIDTH-1:0] o_redirect_pc;
  logic                 o_valid;
  logic                 i_ready;
  logic [CPU_WIDTH-1:0] o_rd_data;
  logic [4:0]           o_rd;
  logic                 o_rd_wen;

  modport master (
    output i_valid, i_kind, i_brop, i_setlt, i_pc, i_imm, i_src1, i_src2,
           i_alu_res, i_sububit, i_rd, i_rd_wen, i_ready,
    input  o_ready, o_redirect, o_redirect_pc, o_valid, o_rd_data, o_rd,
           o_rd_wen
  );

  modport slave (
    input  i_valid, i_kind, i_brop, i_setlt, i_pc, i_imm, i_src1, i_src2,
           i_alu_res, i_sububit, i_rd, i_rd_wen, i_ready,
    output o_ready, o_redirect, o_redirect_pc, o_valid, o_rd_data, o_rd,
           o_rd_wen
  );
endinterface

// File: rtl/exu_resolve.sv
// exu_resolve
//   EX-stage result resolver downstream of the ALU. Resolves branch
//   direction/target from the ALU result and borrow, forms the rd value for
//   slt/sltu/jal/jalr, emits a registered one-cycle redirect pulse to fetch,
//   and hands results to LSU/WB through a 2-entry valid/ready skid buffer.
//   Ports:
//     i_clk  : clock, rising edge
//     i_rst  : asynchronous active-high reset
//     bus    : exu_resolve_if.slave (upstream, redirect, downstream groups)
module exu_resolve #(
  parameter int CPU_WIDTH = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  exu_resolve_if.slave  bus
);
  localparam int MSB = CPU_WIDTH - 1;
  localparam int EW  = CPU_WIDTH + 6;   // {data, rd, wen}

  localparam logic [1:0] KIND_ALU  = 2'd0;
  localparam logic [1:0] KIND_BR   = 2'd1;
  localparam logic [1:0] KIND_JAL  = 2'd2;
  localparam logic [1:0] KIND_JALR = 2'd3;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [1:0] SET_SLT  = 2'd1;
  localparam logic [1:0] SET_SLTU = 2'd2;

  localparam logic [CPU_WIDTH-1:0] ZERO_W  = {CPU_WIDTH{1'b0}};
  localparam logic [CPU_WIDTH-1:0] PC_STEP = CPU_WIDTH'(32'd4);
  localparam logic [CPU_WIDTH-1:0] LSB_CLR = ~CPU_WIDTH'(32'd1);

  logic                 eq_s;
  logic                 slt_s;
  logic                 ltu_s;
  logic                 taken_s;
  logic                 redir_s;
  logic [CPU_WIDTH-1:0] target_s;
  logic [CPU_WIDTH-1:0] new_data_s;
  logic                 new_wen_s;
  logic [EW-1:0]        new_ent_s;
  logic                 accept_s;

  logic                 redirect_q, redirect_d;
  logic [CPU_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                 out_vld_q, out_vld_d;
  logic [EW-1:0]        out_ent_q, out_ent_d;
  logic                 skid_vld_q, skid_vld_d;
  logic [EW-1:0]        skid_ent_q, skid_ent_d;

  // o_ready comes straight from the skid flag, so accept never overlaps a skid drain.
  assign accept_s  = bus.i_valid && !skid_vld_q;
  assign new_ent_s = {new_data_s, bus.i_rd, new_wen_s};

  // Compare flags derived from the ALU subtract result.
  always_comb begin
    eq_s  = (bus.i_alu_res == ZERO_W);
    ltu_s = bus.i_sububit;
    // Differing signs decide signed order directly; otherwise the difference sign does.
    if (bus.i_src1[MSB] != bus.i_src2[MSB]) begin
      slt_s = bus.i_src1[MSB];
    end else begin
      slt_s = bus.i_alu_res[MSB];
    end
  end

  // Branch direction from funct3.
  always_comb begin
    taken_s = 1'b0;
    case (bus.i_brop)
      BR_BEQ:  taken_s = eq_s;
      BR_BNE:  taken_s = !eq_s;
      BR_BLT:  taken_s = slt_s;
      BR_BGE:  taken_s = !slt_s;
      BR_BLTU: taken_s = ltu_s;
      BR_BGEU: taken_s = !ltu_s;
      default: taken_s = 1'b0;
    endcase
  end

  // Redirect decision and target.
  always_comb begin
    redir_s  = 1'b0;
    target_s = bus.i_pc + bus.i_imm;
    case (bus.i_kind)
      KIND_BR: begin
        redir_s  = taken_s;
        target_s = bus.i_pc + bus.i_imm;
      end
      KIND_JAL: begin
        redir_s  = 1'b1;
        target_s = bus.i_alu_res;
      end
      KIND_JALR: begin
        redir_s  = 1'b1;
        target_s = bus.i_alu_res & LSB_CLR;
      end
      default: begin
        redir_s  = 1'b0;
        target_s = bus.i_pc + bus.i_imm;
      end
    endcase
  end

  // rd write-back value and enable.
  always_comb begin
    new_data_s = bus.i_alu_res;
    new_wen_s  = bus.i_rd_wen;
    case (bus.i_kind)
      KIND_BR: begin
        new_data_s = bus.i_alu_res;
        new_wen_s  = 1'b0;
      end
      KIND_JAL, KIND_JALR: begin
        new_data_s = bus.i_pc + PC_STEP;
      end
      KIND_ALU: begin
        case (bus.i_setlt)
          SET_SLT:  new_data_s = {{(CPU_WIDTH-1){1'b0}}, slt_s};
          SET_SLTU: new_data_s = {{(CPU_WIDTH-1){1'b0}}, ltu_s};
          default:  new_data_s = bus.i_alu_res;
        endcase
      end
      default: begin
        new_data_s = bus.i_alu_res;
      end
    endcase
  end

  // Redirect pulse next state; the target is kept between pulses.
  always_comb begin
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    if (accept_s && redir_s) begin
      redirect_d    = 1'b1;
      redirect_pc_d = target_s;
    end else begin
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
    end
  end

  // Skid buffer next state: out drains or refills first, skid catches one stalled beat.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_ent_d  = out_ent_q;
    skid_vld_d = skid_vld_q;
    skid_ent_d = skid_ent_q;
    if (!out_vld_q || bus.i_ready) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_ent_d  = skid_ent_q;
        skid_vld_d = 1'b0;
      end else if (accept_s) begin
        out_vld_d = 1'b1;
        out_ent_d = new_ent_s;
      end else begin
        out_vld_d = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_vld_d = 1'b1;
        skid_ent_d = new_ent_s;
      end else begin
        skid_vld_d = skid_vld_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= ZERO_W;
      out_vld_q     <= 1'b0;
      out_ent_q     <= {EW{1'b0}};
      skid_vld_q    <= 1'b0;
      skid_ent_q    <= {EW{1'b0}};
    end else begin
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      out_vld_q     <= out_vld_d;
      out_ent_q     <= out_ent_d;
      skid_vld_q    <= skid_vld_d;
      skid_ent_q    <= skid_ent_d;
    end
  end

  assign bus.o_ready       = !skid_vld_q;
  assign bus.o_redirect    = redirect_q;
  assign bus.o_redirect_pc = redirect_pc_q;
  assign bus.o_valid       = out_vld_q;
  assign bus.o_rd_data     = out_ent_q[EW-1:6];
  assign bus.o_rd          = out_ent_q[5:1];
  assign bus.o_rd_wen      = out_ent_q[0];
endmodule

// File: tb/tb_exu_resolve.sv
module tb_exu_resolve;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wen;
  } beat_t;

  typedef struct packed {
    logic        redir;
    logic [31:0] target;
    logic [31:0] data;
    logic        wen;
  } exp_t;

  exu_resolve_if #(.CPU_WIDTH(32)) bus ();

  exu_resolve #(.CPU_WIDTH(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour from architectural meaning (true comparisons of the operands).
  function automatic exp_t model(input logic [1:0] kind, input logic [2:0] brop,
                                 input logic [1:0] setlt, input logic [31:0] pc,
                                 input logic [31:0] imm, input logic [31:0] s1,
                                 input logic [31:0] s2, input logic [31:0] alu,
                                 input logic wen);
    exp_t e;
    logic taken;
    logic lt_s;
    logic lt_u;
    lt_s = $signed(s1) < $signed(s2);
    lt_u = s1 < s2;
    case (brop)
      3'b000:  taken = (s1 == s2);
      3'b001:  taken = (s1 != s2);
      3'b100:  taken = lt_s;
      3'b101:  taken = !lt_s;
      3'b110:  taken = lt_u;
      3'b111:  taken = !lt_u;
      default: taken = 1'b0;
    endcase
    e.redir  = 1'b0;
    e.target = 32'h0;
    e.data   = alu;
    e.wen    = wen;
    if (kind == 2'd1) begin
      e.redir  = taken;
      e.target = pc + imm;
      e.wen    = 1'b0;
    end else if (kind == 2'd2) begin
      e.redir  = 1'b1;
      e.target = alu;
      e.data   = pc + 32'd4;
    end else if (kind == 2'd3) begin
      e.redir  = 1'b1;
      e.target = {alu[31:1], 1'b0};
      e.data   = pc + 32'd4;
    end else begin
      if (setlt == 2'd1) e.data = {31'd0, lt_s};
      else if (setlt == 2'd2) e.data = {31'd0, lt_u};
      else e.data = alu;
    end
    return e;
  endfunction

  task automatic drive(input logic [1:0] kind, input logic [2:0] brop, input logic [1:0] setlt,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [31:0] alu, input logic sub,
                       input logic [4:0] rd, input logic wen);
    bus.i_valid   = 1'b1;
    bus.i_kind    = kind;
    bus.i_brop    = brop;
    bus.i_setlt   = setlt;
    bus.i_pc      = pc;
    bus.i_imm     = imm;
    bus.i_src1    = s1;
    bus.i_src2    = s2;
    bus.i_alu_res = alu;
    bus.i_sububit = sub;
    bus.i_rd      = rd;
    bus.i_rd_wen  = wen;
  endtask

  task automatic test_reset();
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    drive(2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    bus.i_valid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_redirect !== 1'b0 ||
        bus.o_redirect_pc !== 32'h0 || bus.o_rd_data !== 32'h0 || bus.o_rd !== 5'd0 ||
        bus.o_rd_wen !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b ready=%b redir=%b pc=%h data=%h rd=%0d wen=%b required 0 1 0 0 0 0 0",
               bus.o_valid, bus.o_ready, bus.o_redirect, bus.o_redirect_pc, bus.o_rd_data,
               bus.o_rd, bus.o_rd_wen);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_branch();
    bus.i_ready = 1'b1;
    // blt -1 < 1 -> taken
    drive(2'd1, 3'b100, 2'd0, 32'h80000010, 32'h20, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 1'b0, 5'd3, 1'b1);
    tick();
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_redirect !== 1'b1 || bus.o_redirect_pc !== 32'h80000030) begin
      failures++;
      $display("FAIL blt_redirect: got %b/%h required 1/80000030", bus.o_redirect, bus.o_redirect_pc);
    end
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_rd_wen !== 1'b0) begin
      failures++;
      $display("FAIL blt_wen: valid=%b wen=%b required 1 0", bus.o_valid, bus.o_rd_wen);
    end
    tick();
    checks++;
    if (bus.o_redirect !== 1'b0 || bus.o_valid !== 1'b0) begin
      failures++;
      $display("FAIL blt_pulse_end: redir=%b valid=%b required 0 0", bus.o_redirect, bus.o_valid);
    end
    // bltu 0xFFFFFFFF < 1 unsigned -> not taken
    drive(2'd1, 3'b110, 2'd0, 32'h80000010, 32'h20, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 1'b0, 5'd3, 1'b1);
    tick();
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_redirect !== 1'b0) begin
      failures++;
      $display("FAIL bltu_no_redirect: got %b required 0", bus.o_redirect);
    end
    // bgeu same operands -> taken
    drive(2'd1, 3'b111, 2'd0, 32'h80000010, 32'h20, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 1'b0, 5'd3, 1'b1);
    tick();
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_redirect !== 1'b1 || bus.o_redirect_pc !== 32'h80000030) begin
      failures++;
      $display("FAIL bgeu_redirect: got %b/%h required 1/80000030", bus.o_redirect, bus.o_redirect_pc);
    end
    tick();
  endtask

  task automatic test_jump();
    bus.i_ready = 1'b1;
    drive(2'd3, 3'd0, 2'd0, 32'h80000100, 32'h0, 32'h0, 32'h0, 32'h80001235, 1'b0, 5'd1, 1'b1);
    tick();
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_redirect !== 1'b1 || bus.o_redirect_pc !== 32'h80001234) begin
      failures++;
      $display("FAIL jalr_target: got %b/%h required 1/80001234", bus.o_redirect, bus.o_redirect_pc);
    end
    checks++;
    if (bus.o_rd_data !== 32'h80000104 || bus.o_rd_wen !== 1'b1 || bus.o_rd !== 5'd1) begin
      failures++;
      $display("FAIL jalr_link: data=%h wen=%b rd=%0d required 80000104 1 1",
               bus.o_rd_data, bus.o_rd_wen, bus.o_rd);
    end
    // jal at the top of the address space: link wraps to 0
    drive(2'd2, 3'd0, 2'd0, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 32'h00000201, 1'b0, 5'd5, 1'b1);
    tick();
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_rd_data !== 32'h0 || bus.o_redirect_pc !== 32'h00000201) begin
      failures++;
      $display("FAIL jal_wrap: data=%h pc=%h required 00000000 00000201", bus.o_rd_data, bus.o_redirect_pc);
    end
    tick();
  endtask

  task automatic test_setlt();
    bus.i_ready = 1'b1;
    drive(2'd0, 3'd0, 2'd2, 32'h0, 32'h0, 32'h1, 32'h2, 32'hFFFFFFFF, 1'b1, 5'd7, 1'b1);
    tick();
    checks++;
    if (bus.o_rd_data !== 32'h1 || bus.o_redirect !== 1'b0) begin
      failures++;
      $display("FAIL sltu_one: data=%h redir=%b required 00000001 0", bus.o_rd_data, bus.o_redirect);
    end
    drive(2'd0, 3'd0, 2'd1, 32'h0, 32'h0, 32'h5, 32'hFFFFFFFF, 32'h6, 1'b1, 5'd7, 1'b1);
    tick();
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_rd_data !== 32'h0 || bus.o_valid !== 1'b1) begin
      failures++;
      $display("FAIL slt_zero: data=%h valid=%b required 00000000 1", bus.o_rd_data, bus.o_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] seen [3];
    bus.i_ready = 1'b0;
    drive(2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA, 1'b0, 5'd10, 1'b1);
    tick();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_rd_data !== 32'hA || bus.o_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_a: valid=%b data=%h ready=%b required 1 0000000a 1",
               bus.o_valid, bus.o_rd_data, bus.o_ready);
    end
    drive(2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hB, 1'b0, 5'd11, 1'b1);
    tick();
    checks++;
    if (bus.o_ready !== 1'b0 || bus.o_rd_data !== 32'hA) begin
      failures++;
      $display("FAIL b2b_full: ready=%b data=%h required 0 0000000a", bus.o_ready, bus.o_rd_data);
    end
    drive(2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hC, 1'b0, 5'd12, 1'b1);
    tick(); tick();
    checks++;
    if (bus.o_ready !== 1'b0 || bus.o_rd_data !== 32'hA || bus.o_rd !== 5'd10 || bus.o_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_hold: ready=%b data=%h rd=%0d valid=%b required 0 0000000a 10 1",
               bus.o_ready, bus.o_rd_data, bus.o_rd, bus.o_valid);
    end
    seen[0] = bus.o_rd_data;
    bus.i_ready = 1'b1;
    tick();
    seen[1] = bus.o_rd_data;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_drain_ready: ready=%b valid=%b required 1 1", bus.o_ready, bus.o_valid);
    end
    tick();
    bus.i_valid = 1'b0;
    seen[2] = bus.o_rd_data;
    checks++;
    if (seen[0] !== 32'hA || seen[1] !== 32'hB || seen[2] !== 32'hC || bus.o_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_order: got %h %h %h required a b c", seen[0], seen[1], seen[2]);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_empty: valid=%b required 0", bus.o_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.i_ready = 1'b0;
    drive(2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11, 1'b0, 5'd1, 1'b1);
    tick();
    drive(2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h22, 1'b0, 5'd2, 1'b1);
    tick();
    bus.i_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_async: valid=%b ready=%b data=%h required 0 1 0",
               bus.o_valid, bus.o_ready, bus.o_rd_data);
    end
    tick();
    rst = 1'b0;
    bus.i_ready = 1'b1;
    tick(); tick();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_stale: valid=%b ready=%b required 0 1", bus.o_valid, bus.o_ready);
    end
  endtask

  // Random traffic against a FIFO model; entered with the block empty and redirect_pc=0.
  task automatic test_random(input int n);
    beat_t       q[$];
    logic [31:0] last_pc;
    logic [31:0] s1, s2, alu;
    logic [1:0]  kind, setlt;
    logic [2:0]  brop;
    logic        acc;
    exp_t        e;
    beat_t       b;
    last_pc = 32'h0;
    for (int i = 0; i < n; i++) begin
      kind  = 2'($urandom_range(0, 3));
      brop  = 3'($urandom_range(0, 7));
      setlt = 2'($urandom_range(0, 2));
      s1    = $urandom;
      case ($urandom_range(0, 3))
        0:       s2 = s1;
        1:       s2 = {~s1[31], s1[30:0]};
        default: s2 = $urandom;
      endcase
      if (kind >= 2'd2 || (kind == 2'd0 && setlt == 2'd0)) alu = $urandom;
      else alu = s1 - s2;
      drive(kind, brop, setlt, $urandom, $urandom, s1, s2, alu, s1 < s2,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      bus.i_valid = ($urandom_range(0, 3) != 0);
      bus.i_ready = ($urandom_range(0, 2) != 0);
      e   = model(kind, brop, setlt, bus.i_pc, bus.i_imm, s1, s2, alu, bus.i_rd_wen);
      acc = bus.i_valid && (q.size() < 2);
      if (q.size() > 0 && bus.i_ready) void'(q.pop_front());
      if (acc) begin
        b.data = e.data; b.rd = bus.i_rd; b.wen = e.wen;
        q.push_back(b);
      end
      if (acc && e.redir) last_pc = e.target;
      tick();
      checks++;
      if (bus.o_ready !== (q.size() < 2) || bus.o_valid !== (q.size() > 0)) begin
        failures++;
        $display("FAIL rand_hs[%0d]: ready=%b valid=%b required %b %b", i, bus.o_ready,
                 bus.o_valid, q.size() < 2, q.size() > 0);
      end
      if (q.size() > 0) begin
        checks++;
        if (bus.o_rd_data !== q[0].data || bus.o_rd !== q[0].rd || bus.o_rd_wen !== q[0].wen) begin
          failures++;
          $display("FAIL rand_data[%0d]: got %h/%0d/%b required %h/%0d/%b", i, bus.o_rd_data,
                   bus.o_rd, bus.o_rd_wen, q[0].data, q[0].rd, q[0].wen);
        end
      end
      checks++;
      if (bus.o_redirect !== (acc && e.redir) || bus.o_redirect_pc !== last_pc) begin
        failures++;
        $display("FAIL rand_redirect[%0d]: got %b/%h required %b/%h", i, bus.o_redirect,
                 bus.o_redirect_pc, acc && e.redir, last_pc);
      end
    end
    bus.i_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    test_reset();
    test_branch();
    test_jump();
    test_setlt();
    test_back_to_back();
    test_reset_mid();
    test_random(600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
